bus_arbiter: RTL and testbench

Round-robin bus arbiter that serves NUM_CLIENTS `client` request/acknowledge interfaces and owns the shared single-port memory they access. It sits directly downstream of the `client` instances. It consumes their `rq`/`address`/`wr_ni`/`dataW` and returns `ack`/`dataR`. Exactly one transaction is in flight at a time; each transaction takes three cycles.

---
 rtl/bus_arb_pkg.sv | 31 +++
 rtl/bus_mem.sv | 56 +++++
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared definitions for the round-robin bus arbiter:
//   state_e   - arbiter FSM state encoding (IDLE, ACCESS, RESP)
//   OP_WR     - wr_ni value for a write
//   OP_RD     - wr_ni value for a read
//   rr_index  - base + offset wrapped into 0..n-1 without a divider
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    // base and offset are both below n, so one conditional subtract wraps the
    // sum correctly even when n is not a power of two.
    function automatic int rr_index(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bus_mem.sv
// -----------------------------------------------------------------------------
// bus_mem
// Single-port synchronous RAM, 2^ADDR_WIDTH x DATA_WIDTH, registered read port.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-low; clears rdata and blocks a write at the
//            same edge (the array itself keeps its contents)
//   we     - write enable: mem[addr] <= wdata
//   re     - read enable: rdata <= mem[addr]; rdata holds otherwise
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data
// -----------------------------------------------------------------------------
module bus_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: the array is deliberately not reset so it maps onto a plain RAM and
    // keeps its contents across reset; reset only gates the write enable.
    always_ff @(posedge clk) begin
        if (reset && we) begin
            mem[addr] <= wdata;
        end
    end

    // rdata holds between reads so a write transaction leaves it unchanged.
    always_comb begin
        rdata_d = re ? mem[addr] : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter in front of a shared single-port memory. One transaction
// is in flight at a time and takes three cycles: IDLE (grant + capture),
// ACCESS (memory operation), RESP (ack pulse, pointer advance).
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-low reset
//   rq        - per-client request, bit i = client i
//   wr_ni     - per-client operation, 1 = write, 0 = read
//   address   - packed addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   dataW     - packed write data, client i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack       - one-cycle acknowledge to the granted client
//   dataR     - read data, valid while ack of a read is high
//   grant_id  - index of the current or last granted client
//   busy      - high in ACCESS and RESP
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_CLIENTS = 4,
    parameter int ID_WIDTH    = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            rq,
    input  logic [NUM_CLIENTS-1:0]            wr_ni,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW,
    output logic [NUM_CLIENTS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]             dataR,
    output logic [ID_WIDTH-1:0]               grant_id,
    output logic                              busy
);

    state_e                  state_d,    state_q;
    logic [ID_WIDTH-1:0]     ptr_d,      ptr_q;
    logic [ID_WIDTH-1:0]     grant_id_d, grant_id_q;
    logic [ADDR_WIDTH-1:0]   addr_d,     addr_q;
    logic                    wr_d,       wr_q;
    logic [DATA_WIDTH-1:0]   wdata_d,    wdata_q;
    logic [NUM_CLIENTS-1:0]  ack_d,      ack_q;
    logic                    busy_d,     busy_q;

    logic [ID_WIDTH-1:0]     win_id;
    logic [ID_WIDTH-1:0]     cand_id;
    logic                    mem_we;
    logic                    mem_re;

    // Round-robin pick: walk the search order from the far end back to ptr so
    // the last hit, i.e. the first requester at or after ptr, wins.
    always_comb begin
        win_id  = '0;
        cand_id = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            cand_id = ID_WIDTH'(rr_index(int'(ptr_q), i, NUM_CLIENTS));
            if (rq[cand_id]) begin
                win_id = cand_id;
            end
        end
    end

    // NOTE: every signal gets a default (its held value) at the top of the
    // block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        ack_d      = '0;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (rq != '0) begin
                    grant_id_d = win_id;
                    addr_d     = address[win_id*ADDR_WIDTH +: ADDR_WIDTH];
                    wr_d       = wr_ni[win_id];
                    wdata_d    = dataW[win_id*DATA_WIDTH +: DATA_WIDTH];
                    state_d    = ST_ACCESS;
                    busy_d     = 1'b1;
                end
            end
            ST_ACCESS: begin
                // ack is registered, so raising it here makes it visible for
                // exactly the RESP cycle, alongside the freshly read dataR.
                ack_d[grant_id_q] = 1'b1;
                state_d           = ST_RESP;
                busy_d            = 1'b1;
            end
            ST_RESP: begin
                ptr_d   = (grant_id_q == ID_WIDTH'(NUM_CLIENTS - 1)) ? '0
                                                                     : grant_id_q + 1'b1;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            addr_q     <= '0;
            wr_q       <= OP_RD;
            wdata_q    <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    // The memory operation completes at the edge that closes ACCESS; reset at
    // that edge suppresses the write inside bus_mem.
    assign mem_we = (state_q == ST_ACCESS) && (wr_q == OP_WR);
    assign mem_re = (state_q == ST_ACCESS) && (wr_q == OP_RD);

    bus_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (dataR)
    );

    assign ack      = ack_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (DATA_WIDTH=8, ADDR_WIDTH=4,
// NUM_CLIENTS=4). A transaction-level reference model (memory array, rotating
// pointer, last read value) predicts grant order, ack timing and read data.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int NC = 4;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     rq;
    logic [NC-1:0]     wr_ni;
    logic [NC*AW-1:0]  address;
    logic [NC*DW-1:0]  dataW;
    logic [NC-1:0]     ack;
    logic [DW-1:0]     dataR;
    logic [IW-1:0]     grant_id;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [16];
    bit            ref_known [16];
    int            ref_ptr;
    logic [DW-1:0] ref_dataR;
    bit            ref_dataR_known;

    // Per-client operation presented when that client requests
    logic          op_wr   [NC];
    logic [AW-1:0] op_addr [NC];
    logic [DW-1:0] op_data [NC];

    bus_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .NUM_CLIENTS (NC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rq       (rq),
        .wr_ni    (wr_ni),
        .address  (address),
        .dataW    (dataW),
        .ack      (ack),
        .dataR    (dataR),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic set_op(input int c, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        op_wr[c]   = w;
        op_addr[c] = a;
        op_data[c] = d;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NC; i++) begin
            wr_ni[i]            = op_wr[i];
            address[i*AW +: AW] = op_addr[i];
            dataW[i*DW +: DW]   = op_data[i];
        end
    endtask

    // Raise rq for every client in 'set' at once, then follow the acks. The
    // model orders the batch by rotating priority from ref_ptr; each client
    // drops rq as soon as it sees its ack.
    task automatic run_batch(input logic [NC-1:0] set, output int first_win);
        int            order[$];
        logic [NC-1:0] pend;
        logic [NC-1:0] exp_ack;
        logic [DW-1:0] exp_d;
        bit            got;
        bit            chk;
        int            p, w, gap, exp_gap, idx;

        pend = set;
        p    = ref_ptr;
        while (pend != '0) begin
            for (int i = 0; i < NC; i++) begin
                idx = (p + i) % NC;
                if (pend[idx]) begin
                    order.push_back(idx);
                    pend[idx] = 1'b0;
                    p         = (idx + 1) % NC;
                    break;
                end
            end
        end

        @(negedge clk);
        drive_ops();
        rq        = set;
        first_win = -1;

        for (int k = 0; k < order.size(); k++) begin
            w   = order[k];
            got = 1'b0;
            gap = 0;
            while (!got && gap < 20) begin
                @(negedge clk);
                gap++;
                if (ack !== '0) got = 1'b1;
            end
            vectors++;
            if (!got) begin
                $display("FAIL ack_timeout: client %0d saw no ack within %0d cycles", w, gap);
                miscompares++;
                rq      = '0;
                ref_ptr = p;
                return;
            end
            exp_gap = (k == 0) ? 2 : 3;
            if (gap !== exp_gap) begin
                $display("FAIL ack_spacing: client %0d ack after %0d cycles, expected %0d",
                         w, gap, exp_gap);
                miscompares++;
            end
            exp_ack    = '0;
            exp_ack[w] = 1'b1;
            vectors++;
            if (ack !== exp_ack) begin
                $display("FAIL ack_onehot: got %b expected %b", ack, exp_ack);
                miscompares++;
            end
            if (k == 0) begin
                for (int j = NC - 1; j >= 0; j--) begin
                    if (ack[j] === 1'b1) first_win = j;
                end
            end
            vectors++;
            if (grant_id !== IW'(w)) begin
                $display("FAIL grant_id: got %0d expected %0d", grant_id, w);
                miscompares++;
            end
            vectors++;
            if (busy !== 1'b1) begin
                $display("FAIL busy_in_resp: got %b expected 1", busy);
                miscompares++;
            end
            if (op_wr[w]) begin
                exp_d                 = ref_dataR;
                chk                   = ref_dataR_known;
                ref_mem[op_addr[w]]   = op_data[w];
                ref_known[op_addr[w]] = 1'b1;
            end else begin
                exp_d           = ref_mem[op_addr[w]];
                chk             = ref_known[op_addr[w]];
                ref_dataR       = exp_d;
                ref_dataR_known = chk;
            end
            if (chk) begin
                vectors++;
                if (dataR !== exp_d) begin
                    $display("FAIL dataR: client %0d %s addr %0d got %h expected %h",
                             w, op_wr[w] ? "write" : "read", op_addr[w], dataR, exp_d);
                    miscompares++;
                end
            end
            rq[w] = 1'b0;
        end
        ref_ptr = p;

        @(negedge clk);
        vectors++;
        if (ack !== '0 || busy !== 1'b0) begin
            $display("FAIL idle_after_batch: ack=%b busy=%b expected ack=0 busy=0", ack, busy);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rq    = '1;
        for (int i = 0; i < NC; i++) set_op(i, 1'b1, '0, '0);
        drive_ops();
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (ack !== '0)    begin $display("FAIL reset_ack: got %b expected 0", ack); miscompares++; end
            vectors++;
            if (dataR !== '0)  begin $display("FAIL reset_dataR: got %h expected 0", dataR); miscompares++; end
            vectors++;
            if (grant_id !== '0) begin $display("FAIL reset_grant_id: got %0d expected 0", grant_id); miscompares++; end
            vectors++;
            if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy); miscompares++; end
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (ack !== '0 || busy !== 1'b1) begin
            $display("FAIL post_reset_access: ack=%b busy=%b expected ack=0 busy=1", ack, busy);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (ack !== 4'b0001) begin
            $display("FAIL post_reset_first_ack: got %b expected 0001", ack);
            miscompares++;
        end
        rq = '0;
        @(negedge clk);
        vectors++;
        if (ack !== '0 || busy !== 1'b0) begin
            $display("FAIL post_reset_idle: ack=%b busy=%b expected ack=0 busy=0", ack, busy);
            miscompares++;
        end
        ref_ptr         = 1;
        ref_mem[0]      = '0;
        ref_known[0]    = 1'b1;
        ref_dataR       = '0;
        ref_dataR_known = 1'b1;
    endtask

    task automatic test_write_read();
        int fw;
        set_op(1, 1'b1, 4'd3, 8'hA5);
        run_batch(4'b0010, fw);
        set_op(1, 1'b0, 4'd3, 8'h00);
        run_batch(4'b0010, fw);
        vectors++;
        if (dataR !== 8'hA5) begin
            $display("FAIL read_back_hold: got %h expected a5", dataR);
            miscompares++;
        end
    endtask

    task automatic test_all_request();
        int fw;
        // One access by client 3 moves the pointer back to 0 first.
        set_op(3, 1'b0, 4'd3, 8'h00);
        run_batch(4'b1000, fw);
        for (int i = 0; i < NC; i++) set_op(i, 1'b1, AW'(8 + i), DW'(8'h40 + i));
        run_batch(4'b1111, fw);
        vectors++;
        if (fw !== 0) begin
            $display("FAIL all_request_first: got %0d expected 0", fw);
            miscompares++;
        end
    endtask

    task automatic test_priority();
        int fw;
        set_op(2, 1'b0, 4'd8, 8'h00);
        run_batch(4'b0100, fw);
        set_op(0, 1'b0, 4'd9, 8'h00);
        set_op(2, 1'b0, 4'd10, 8'h00);
        run_batch(4'b0101, fw);
        vectors++;
        if (fw !== 0) begin
            $display("FAIL priority_after_ptr3: got %0d expected 0", fw);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_access();
        int fw;
        set_op(1, 1'b1, 4'd5, 8'h11);
        run_batch(4'b0010, fw);
        @(negedge clk);
        set_op(0, 1'b1, 4'd5, 8'h3C);
        drive_ops();
        rq = 4'b0001;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || ack !== '0) begin
            $display("FAIL mid_access_state: busy=%b ack=%b expected busy=1 ack=0", busy, ack);
            miscompares++;
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (ack !== '0)   begin $display("FAIL mid_reset_ack: got %b expected 0", ack); miscompares++; end
        vectors++;
        if (busy !== 1'b0) begin $display("FAIL mid_reset_busy: got %b expected 0", busy); miscompares++; end
        vectors++;
        if (dataR !== '0) begin $display("FAIL mid_reset_dataR: got %h expected 0", dataR); miscompares++; end
        rq    = '0;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (ack !== '0) begin $display("FAIL post_mid_reset_ack: got %b expected 0", ack); miscompares++; end
        ref_ptr         = 0;
        ref_dataR       = '0;
        ref_dataR_known = 1'b1;
        set_op(0, 1'b0, 4'd5, 8'h00);
        run_batch(4'b0001, fw);
        vectors++;
        if (dataR !== 8'h11) begin
            $display("FAIL write_suppressed: got %h expected 11", dataR);
            miscompares++;
        end
    endtask

    task automatic test_addr_wrap();
        int fw;
        set_op(3, 1'b1, 4'd15, 8'hFF);
        run_batch(4'b1000, fw);
        set_op(3, 1'b0, 4'd15, 8'h00);
        run_batch(4'b1000, fw);
        vectors++;
        if (dataR !== 8'hFF) begin
            $display("FAIL addr15_read: got %h expected ff", dataR);
            miscompares++;
        end
        set_op(0, 1'b0, 4'd15, 8'h00);
        set_op(3, 1'b0, 4'd0, 8'h00);
        run_batch(4'b1001, fw);
        vectors++;
        if (fw !== 0) begin
            $display("FAIL ptr_wrap_first: got %0d expected 0", fw);
            miscompares++;
        end
    endtask

    task automatic test_random();
        int            fw;
        logic [NC-1:0] set;
        for (int n = 0; n < 40; n++) begin
            set = NC'($urandom_range(1, 15));
            for (int i = 0; i < NC; i++) begin
                set_op(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            end
            run_batch(set, fw);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_known[i] = 1'b0;
            ref_mem[i]   = '0;
        end
        ref_ptr         = 0;
        ref_dataR       = '0;
        ref_dataR_known = 1'b1;
        rq      = '0;
        wr_ni   = '0;
        address = '0;
        dataW   = '0;
        reset   = 1'b0;

        test_reset();
        test_write_read();
        test_all_request();
        test_priority();
        test_reset_mid_access();
        test_addr_wrap();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
